// File: rtl/srt_normalizer.sv
// ---------------------------------------------------------------------------
// srt_normalizer
//   Operand pre-normalization stage in front of the SRT divider. It accepts
//   an unsigned dividend/divisor pair. It then left-shifts the divisor until
//   its MSB is set. The dividend is shifted by the same amount into a 2W-wide
//   partial-remainder image. The shift count is reported so the divider can
//   denormalize the remainder. A zero divisor is flagged through div0.
//
//   The divisor is normalized by a multi-cycle scan. While the top STEP bits
//   are all zero, the scan takes coarse steps of STEP bits. After that it
//   takes single-bit steps.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     dvd/dsr valid
//   in_ready   out  1     block idle, can accept an operand pair
//   dvd        in   W     dividend, unsigned
//   dsr        in   W     divisor, unsigned
//   out_valid  out  1     normalized result valid, held until accepted
//   out_ready  in   1     downstream divider accepts the result
//   ndvd       out  2W    {W'b0,dvd} << shift
//   ndsr       out  W     dsr << shift, MSB set unless div0
//   shift      out  SW    leading-zero count of dsr (0..W-1)
//   div0       out  1     dsr was zero
// ---------------------------------------------------------------------------
module srt_normalizer #(
  parameter int W    = 64,
  parameter int STEP = 8,
  parameter int SW   = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    dvd,
  input  logic [W-1:0]    dsr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  ndvd,
  output logic [W-1:0]    ndsr,
  output logic [SW-1:0]   shift,
  output logic            div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*W-1:0] dvd_r;
  logic [W-1:0]   dsr_r;

  logic dsr_zero;
  logic dsr_norm;
  logic top_clear;

  // Scan decisions on the working divisor. top_clear is only acted on when
  // dsr_r is nonzero. So a coarse step can never push set bits out of the top.
  assign dsr_zero  = (dsr_r == '0);
  assign dsr_norm  = dsr_r[W-1];
  assign top_clear = (dsr_r[W-1 -: STEP] == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. in_ready is purely combinational from
  // the state. So it reads 1 while reset is held.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (dsr_zero || dsr_norm) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured on acceptance and shifted during SCAN.
  // ndvd/ndsr are loaded only on the final SCAN edge. The published result
  // therefore stays frozen for the whole DONE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r <= '0;
      dsr_r <= '0;
      ndvd  <= '0;
      ndsr  <= '0;
      shift <= '0;
      div0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= {{W{1'b0}}, dvd};
            dsr_r <= dsr;
            shift <= '0;
            div0  <= 1'b0;
          end
        end
        SCAN: begin
          if (dsr_zero) begin
            div0  <= 1'b1;
            ndsr  <= '0;
            ndvd  <= dvd_r;
            shift <= '0;
          end else if (dsr_norm) begin
            ndsr <= dsr_r;
            ndvd <= dvd_r;
          end else if (top_clear) begin
            dsr_r <= dsr_r << STEP;
            dvd_r <= dvd_r << STEP;
            shift <= shift + SW'(STEP);
          end else begin
            dsr_r <= dsr_r << 1;
            dvd_r <= dvd_r << 1;
            shift <= shift + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srt_normalizer.sv
// ---------------------------------------------------------------------------
// tb_srt_normalizer
//   Scoreboard bench for srt_normalizer (W=64, STEP=8). The driver pushes
//   the expected result for every accepted pair. It uses literal values for
//   the directed cases and a leading-zero reference model for random pairs.
//   An independent monitor pops each entry when out_valid rises. It checks
//   the latency and the result fields. It keeps checking stability and
//   in_ready while the result is held, and it drives out_ready backpressure.
// ---------------------------------------------------------------------------
module tb_srt_normalizer;

  localparam int W    = 64;
  localparam int STEP = 8;
  localparam int SW   = $clog2(W);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    dvd;
  logic [W-1:0]    dsr;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  ndvd;
  logic [W-1:0]    ndsr;
  logic [SW-1:0]   shift;
  logic            div0;

  typedef struct {
    logic [2*W-1:0] ndvd;
    logic [W-1:0]   ndsr;
    logic [SW-1:0]  shift;
    logic           div0;
    int             latency;
    int             accept_cycle;
    int             stall;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cycle;

  srt_normalizer #(.W(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dvd       (dvd),
    .dsr       (dsr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ndvd      (ndvd),
    .ndsr      (ndsr),
    .shift     (shift),
    .div0      (div0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges. The edge that accepts a pair is the latency origin.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model. A nonzero divisor is shifted by its leading-zero count.
  // The scan needs lz/STEP coarse steps, lz%STEP fine steps and one final
  // edge. A zero divisor finishes on the first scan edge.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   lz;
    lz = 0;
    if (b == '0) begin
      e.div0    = 1'b1;
      e.shift   = '0;
      e.ndsr    = '0;
      e.ndvd    = {{W{1'b0}}, a};
      e.latency = 1;
    end else begin
      while (b[W-1-lz] == 1'b0) lz++;
      e.div0    = 1'b0;
      e.shift   = SW'(lz);
      e.ndsr    = b << lz;
      e.ndvd    = {{W{1'b0}}, a} << lz;
      e.latency = lz / STEP + lz % STEP + 1;
    end
    e.accept_cycle = 0;
    e.stall        = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [2*W-1:0] v_ndvd, input logic [W-1:0] v_ndsr,
                              input int v_shift, input logic v_div0, input int v_lat);
    exp_t e;
    e.ndvd         = v_ndvd;
    e.ndsr         = v_ndsr;
    e.shift        = SW'(v_shift);
    e.div0         = v_div0;
    e.latency      = v_lat;
    e.accept_cycle = 0;
    e.stall        = 0;
    return e;
  endfunction

  // Present a pair and hold it until accepted. Call at a falling edge.
  // Returns at the falling edge one cycle after acceptance.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input exp_t e, input int stall);
    int n;
    exp_t x;
    x        = e;
    dvd      = a;
    dsr      = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready=0 required=in_ready=1");
    end else begin
      x.accept_cycle = cycle + 1;
      x.stall        = stall;
      sb.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && in_ready && !out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=pending=%0d required=pending=0", sb.size());
    end
  endtask

  // Monitor. It pops one expected entry when out_valid rises and compares
  // the result on every cycle it is held. It releases the result after the
  // entry's stall count has elapsed.
  exp_t cur;
  logic has_cur;
  logic prev_valid;
  logic released;
  int   stall_left;

  initial begin
    has_cur    = 1'b0;
    prev_valid = 1'b0;
    released   = 1'b0;
    stall_left = 0;
    out_ready  = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      released   = 1'b0;
      has_cur    = 1'b0;
      out_ready  = 1'b0;
    end else begin
      if (released) begin
        check_output("release_out_valid", 128'(out_valid), 128'(1'b0));
        check_output("release_in_ready", 128'(in_ready), 128'(1'b1));
        released = 1'b0;
      end
      if (out_valid) begin
        assert (int'(shift) < W);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            has_cur = 1'b0;
            $display("[TB] FAIL unexpected_output actual=out_valid=1 required=no_pending_pair");
          end else begin
            cur        = sb.pop_front();
            has_cur    = 1'b1;
            stall_left = cur.stall;
            check_output("latency", 128'(cycle - cur.accept_cycle), 128'(cur.latency));
          end
        end
        if (has_cur) begin
          check_output("ndvd", ndvd, cur.ndvd);
          check_output("ndsr", 128'(ndsr), 128'(cur.ndsr));
          check_output("shift", 128'(shift), 128'(cur.shift));
          check_output("div0", 128'(div0), 128'(cur.div0));
        end
        check_output("busy_in_ready", 128'(in_ready), 128'(1'b0));
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          released  = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dvd      = '0;
    dsr      = '0;
    repeat (3) @(negedge clk);
    check_output("reset_in_ready", 128'(in_ready), 128'(1'b1));
    check_output("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check_output("reset_ndvd", ndvd, 128'(0));
    check_output("reset_ndsr", 128'(ndsr), 128'(0));
    check_output("reset_shift", 128'(shift), 128'(0));
    check_output("reset_div0", 128'(div0), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with literal expectations.
    apply_stimulus(64'd74, 64'd21,
                   mk({64'h2, 64'h5000_0000_0000_0000}, 64'hA800_0000_0000_0000, 59, 1'b0, 11), 0);
    wait_idle();
    apply_stimulus(64'd5, 64'h8000_0000_0000_0000,
                   mk(128'd5, 64'h8000_0000_0000_0000, 0, 1'b0, 1), 1);
    wait_idle();
    apply_stimulus(64'h1234, 64'd0, mk(128'h1234, 64'd0, 0, 1'b1, 1), 0);
    wait_idle();
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                   mk({64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
                      64'h8000_0000_0000_0000, 63, 1'b0, 15), 2);
    wait_idle();

    // Backpressure: the result is held for 5 cycles. A second pair is
    // offered while the block is busy and must not be captured.
    apply_stimulus(64'd74, 64'd21,
                   mk({64'h2, 64'h5000_0000_0000_0000}, 64'hA800_0000_0000_0000, 59, 1'b0, 11), 5);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("busy_wait_out_valid", 128'(out_valid), 128'(1'b1));
    dvd      = 64'd99;
    dsr      = 64'd1;
    in_valid = 1'b1;
    repeat (2) begin
      check_output("busy_pulse_in_ready", 128'(in_ready), 128'(1'b0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check_output("busy_pair_dropped", 128'(sb.size() == 0 && !out_valid), 128'(1'b1));

    // Reset in the 4th scan cycle aborts the operation.
    apply_stimulus(64'd74, 64'd21,
                   mk({64'h2, 64'h5000_0000_0000_0000}, 64'hA800_0000_0000_0000, 59, 1'b0, 11), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_output("abort_out_valid", 128'(out_valid), 128'(1'b0));
    check_output("abort_in_ready", 128'(in_ready), 128'(1'b1));
    check_output("abort_shift", 128'(shift), 128'(0));
    check_output("abort_ndvd", ndvd, 128'(0));
    check_output("abort_ndsr", 128'(ndsr), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(64'd7, 64'd3,
                   mk({64'h1, 64'hC000_0000_0000_0000}, 64'hC000_0000_0000_0000, 62, 1'b0, 14), 0);
    wait_idle();

    // Random pairs checked against the reference model. The divisor gets a
    // chosen leading-zero count, with zero included. The pairs are issued
    // back to back with random backpressure.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      n = $urandom_range(0, 64);
      b = ({$urandom, $urandom} | 64'h8000_0000_0000_0000) >> n;
      if (n == 64) b = '0;
      apply_stimulus(a, b, model(a, b), $urandom_range(0, 3));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
